// File: rtl/mc_bank_timing_ctrl.sv
// mc_bank_timing_ctrl: per-bank DRAM command timing controller.
// Each bank runs a CLOSED/ACTIVATING/OPEN/PRECHARGING FSM with its own
// down-counter. cmd_ready gates commands on bank state. A fixed-latency
// shift register schedules the read-data return pulses.
// Optional feature: define MC_TIMING_TRAS_CHECK_EN to enforce ACT-to-PRE (tRAS).
module mc_bank_timing_ctrl #(
    parameter int NUM_BANKS   = 4,
    parameter int T_RCD       = 14,
    parameter int CAS_LATENCY = 14,
    parameter int T_RP        = 14,
    parameter int T_RAS       = 32,
    localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    input  logic [3:0]           cmd_type,
    input  logic [BANK_W-1:0]    cmd_bank,
    output logic                 cmd_ready,
    output logic                 issue_valid,
    output logic [3:0]           issue_type,
    output logic [BANK_W-1:0]    issue_bank,
    output logic                 rd_data_valid,
    output logic [BANK_W-1:0]    rd_bank,
    output logic [NUM_BANKS-1:0] bank_open,
    output logic                 cmd_err
);

    localparam logic [3:0] CMD_ACT   = 4'b0001;
    localparam logic [3:0] CMD_READ  = 4'b0010;
    localparam logic [3:0] CMD_WRITE = 4'b0011;
    localparam logic [3:0] CMD_PRE   = 4'b0100;

    localparam int CNT_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        CLOSED      = 2'd0,
        ACTIVATING  = 2'd1,
        OPEN        = 2'd2,
        PRECHARGING = 2'd3
    } bank_state_t;

    bank_state_t            state_q [NUM_BANKS];
    bank_state_t            state_d [NUM_BANKS];
    logic [CNT_W-1:0]       cnt_q   [NUM_BANKS];
    logic [CNT_W-1:0]       cnt_d   [NUM_BANKS];

`ifdef MC_TIMING_TRAS_CHECK_EN
    localparam int TRAS_W = (T_RAS > 1) ? $clog2(T_RAS) : 1;
    logic [TRAS_W-1:0]      tras_q  [NUM_BANKS];
    logic [TRAS_W-1:0]      tras_d  [NUM_BANKS];
`endif

    logic                   is_act;
    logic                   is_rdwr;
    logic                   is_pre;
    logic                   is_legal;
    logic                   tgt_hit;
    bank_state_t            tgt_state;
    logic                   pre_ok;
    logic                   accept;
    logic                   rd_accept;

    logic [CAS_LATENCY-1:0] rd_vld_p;
    logic [BANK_W-1:0]      rd_bank_p [CAS_LATENCY];

    assign is_act   = (cmd_type == CMD_ACT);
    assign is_rdwr  = (cmd_type == CMD_READ) || (cmd_type == CMD_WRITE);
    assign is_pre   = (cmd_type == CMD_PRE);
    assign is_legal = is_act || is_rdwr || is_pre;

    // Look up the addressed bank's state; an index beyond NUM_BANKS matches nothing
    always_comb begin
        tgt_hit   = 1'b0;
        tgt_state = CLOSED;
        pre_ok    = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (cmd_bank == BANK_W'(b)) begin
                tgt_hit   = 1'b1;
                tgt_state = state_q[b];
`ifdef MC_TIMING_TRAS_CHECK_EN
                pre_ok    = (state_q[b] == OPEN) && (tras_q[b] == '0);
`else
                pre_ok    = (state_q[b] == OPEN);
`endif
            end
        end
    end

    // Acceptance: legal commands wait on bank state, illegal codes pass straight through
    always_comb begin
        cmd_ready = 1'b0;
        if (reset) begin
            cmd_ready = 1'b0;
        end else if (!is_legal) begin
            cmd_ready = 1'b1;
        end else if (tgt_hit) begin
            if (is_act) begin
                cmd_ready = (tgt_state == CLOSED);
            end else if (is_rdwr) begin
                cmd_ready = (tgt_state == OPEN);
            end else begin
                cmd_ready = pre_ok;
            end
        end
    end

    assign accept    = cmd_valid && cmd_ready;
    assign rd_accept = accept && (cmd_type == CMD_READ);

    // Per-bank next state; counters are timed so the follow-on command is legal
    // exactly T_RCD / T_RP cycles after the ACT / PRE was accepted
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            state_d[b] = state_q[b];
            cnt_d[b]   = cnt_q[b];
`ifdef MC_TIMING_TRAS_CHECK_EN
            tras_d[b]  = (tras_q[b] == '0) ? '0 : tras_q[b] - TRAS_W'(1);
            if (accept && is_act && (cmd_bank == BANK_W'(b))) begin
                tras_d[b] = TRAS_W'(T_RAS - 1);
            end
`endif
            case (state_q[b])
                CLOSED: begin
                    if (accept && is_act && (cmd_bank == BANK_W'(b))) begin
                        state_d[b] = (T_RCD == 1) ? OPEN : ACTIVATING;
                        cnt_d[b]   = CNT_W'(T_RCD - 1);
                    end
                end
                ACTIVATING: begin
                    if (cnt_q[b] <= CNT_W'(1)) begin
                        state_d[b] = OPEN;
                        cnt_d[b]   = '0;
                    end else begin
                        cnt_d[b]   = cnt_q[b] - CNT_W'(1);
                    end
                end
                OPEN: begin
                    if (accept && is_pre && (cmd_bank == BANK_W'(b))) begin
                        state_d[b] = (T_RP == 1) ? CLOSED : PRECHARGING;
                        cnt_d[b]   = CNT_W'(T_RP - 1);
                    end
                end
                PRECHARGING: begin
                    if (cnt_q[b] <= CNT_W'(1)) begin
                        state_d[b] = CLOSED;
                        cnt_d[b]   = '0;
                    end else begin
                        cnt_d[b]   = cnt_q[b] - CNT_W'(1);
                    end
                end
                default: begin
                    state_d[b] = CLOSED;
                    cnt_d[b]   = '0;
                end
            endcase
        end
    end

    // Bank state and timing counter registers
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (reset) begin
                state_q[b] <= CLOSED;
                cnt_q[b]   <= '0;
`ifdef MC_TIMING_TRAS_CHECK_EN
                tras_q[b]  <= '0;
`endif
            end else begin
                state_q[b] <= state_d[b];
                cnt_q[b]   <= cnt_d[b];
`ifdef MC_TIMING_TRAS_CHECK_EN
                tras_q[b]  <= tras_d[b];
`endif
            end
        end
    end

    // Issue and error pulses, one cycle after acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_valid <= 1'b0;
            issue_type  <= '0;
            issue_bank  <= '0;
            cmd_err     <= 1'b0;
        end else begin
            issue_valid <= accept && is_legal;
            issue_type  <= cmd_type;
            issue_bank  <= cmd_bank;
            cmd_err     <= accept && !is_legal;
        end
    end

    // Read-return valid pipeline; reset flushes every in-flight READ
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_p <= '0;
        end else begin
            rd_vld_p[0] <= rd_accept;
            for (int i = 1; i < CAS_LATENCY; i++) begin
                rd_vld_p[i] <= rd_vld_p[i-1];
            end
        end
    end

    // Read-return bank pipeline; a stage's content only matters while its valid is set
    always_ff @(posedge clk) begin
        rd_bank_p[0] <= cmd_bank;
        for (int i = 1; i < CAS_LATENCY; i++) begin
            rd_bank_p[i] <= rd_bank_p[i-1];
        end
    end

    assign rd_data_valid = rd_vld_p[CAS_LATENCY-1];
    assign rd_bank       = rd_data_valid ? rd_bank_p[CAS_LATENCY-1] : '0;

    // Open-bank status vector
    always_comb begin
        bank_open = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_open[b] = (state_q[b] == OPEN);
        end
    end

endmodule

// File: doc/mc_bank_timing_ctrl.md
MC_BANK_TIMING_CTRL -- requirements
Module: mc_bank_timing_ctrl

Interface
REQ-001 Parameter NUM_BANKS, default 4, is the number of independently timed banks; legal values are 2..16.
REQ-002 Parameter T_RCD, default 14, is the ACT-to-column-command delay in clk cycles; minimum 1.
REQ-003 Parameter CAS_LATENCY, default 14, is the READ-to-data delay in clk cycles; minimum 1.
REQ-004 Parameter T_RP, default 14, is the PRE-to-ACT delay in clk cycles; minimum 1.
REQ-005 Parameter T_RAS, default 32, is the ACT-to-PRE minimum in clk cycles; minimum 1.
REQ-006 Derived localparam BANK_W = max(1, clog2(NUM_BANKS)) sets the bank-index width.
REQ-007 clk  input  1  is the single clock; all logic is on the rising edge.
REQ-008 reset  input  1  is the synchronous, active-high reset.
REQ-009 cmd_valid  input  1  means a command is presented.
REQ-010 cmd_type  input  4  is the command code: 0001 ACT, 0010 READ, 0011 WRITE, 0100 PRE; all other codes are illegal.
REQ-011 cmd_bank  input  BANK_W  is the target bank.
REQ-012 cmd_ready  output  1  is the combinational acceptance signal; a command is accepted when cmd_valid and cmd_ready are both high.
REQ-013 issue_valid  output  1  is a registered one-cycle pulse, asserted the cycle after each accepted legal command.
REQ-014 issue_type  output  4 and issue_bank  output  BANK_W  hold the type and bank of the issued command; they are valid only while issue_valid is high.
REQ-015 rd_data_valid  output  1 and rd_bank  output  BANK_W  carry a one-cycle pulse marking the return of read data.
REQ-016 bank_open  output  NUM_BANKS  has bit b high while bank b is in OPEN.
REQ-017 cmd_err  output  1  is a registered one-cycle pulse flagging an accepted illegal command code.

Function
REQ-018 Each bank has its own FSM (CLOSED, ACTIVATING, OPEN, PRECHARGING) and its own down-counter.
REQ-019 The FSM transitions are:
- CLOSED -ACT-> ACTIVATING, counter loaded with T_RCD-1.
- ACTIVATING -> OPEN when the counter reaches 0.
- OPEN -PRE-> PRECHARGING, counter loaded with T_RP-1.
- PRECHARGING -> CLOSED when the counter reaches 0.
REQ-020 cmd_ready is high for:
- ACT, when the target bank is CLOSED;
- READ or WRITE, when the target bank is OPEN;
- PRE, when the target bank is OPEN;
- illegal codes, always.
REQ-021 An ACT accepted in cycle N makes a READ or WRITE to that bank acceptable from cycle N+T_RCD, and a PRE accepted in cycle N makes an ACT acceptable from cycle N+T_RP.
REQ-022 A READ accepted in cycle N produces rd_data_valid in cycle N+CAS_LATENCY, with rd_bank equal to the READ's bank.
REQ-023 The read pipeline holds up to CAS_LATENCY outstanding READs, and back-to-back READs on consecutive cycles return on consecutive cycles.
REQ-024 A WRITE produces only issue_valid; it has no data pulse and does not change the bank state.
REQ-025 An illegal code, once accepted, pulses cmd_err the next cycle, does not pulse issue_valid, and changes no bank state.
REQ-026 A command with cmd_ready low is held off: no state change, no pulse, and the requester keeps it presented.
REQ-027 At most one command is accepted per cycle, and the counters of banks not addressed by that command advance unaffected by it.
REQ-028 The rd_data_valid output is independent of cmd_ready, so a READ return and a new acceptance may occur in the same cycle.
REQ-029 A bank may be PREed while READs to it are still in flight, and those READs still return at their scheduled cycle.

Reset
REQ-030 While reset is high at a clk edge, every bank goes to CLOSED, every counter goes to 0, and the read pipeline is flushed.
REQ-031 During and after reset, issue_valid, issue_type, issue_bank, rd_data_valid, rd_bank, cmd_err and bank_open are all 0.
REQ-032 Reset asserted mid-operation discards in-flight READs, so no rd_data_valid occurs after reset.
REQ-033 cmd_ready is 0 while reset is high.

Configuration
REQ-034 When macro MC_TIMING_TRAS_CHECK_EN is defined, each bank keeps a tRAS counter loaded with T_RAS-1 on ACT.
REQ-035 With MC_TIMING_TRAS_CHECK_EN defined, PRE is ready only when the bank is OPEN and its tRAS counter has reached 0.
REQ-036 With MC_TIMING_TRAS_CHECK_EN undefined, the tRAS counter is absent and PRE is ready whenever the bank is OPEN.

Verification
REQ-037 Defaults, ACT bank1 at cycle 10, then READ bank1 held valid from cycle 11 -> READ accepted at cycle 24, issue_valid at 11 and 25, rd_data_valid with rd_bank=1 at cycle 38.
REQ-038 ACT bank0 at 0, ACT bank2 at 1, READ b0 at 14, READ b2 at 15 -> rd_data_valid at 28 (bank0) and 29 (bank2), bank_open=4'b0101 from cycle 15.
REQ-039 PRE bank0 at cycle 40, then ACT bank0 held valid -> ACT accepted at cycle 54 and bank_open[0]=0 in cycles 41..54.
REQ-040 cmd_type=4'b1111 -> accepted, cmd_err pulses once, issue_valid stays 0, bank_open unchanged.
REQ-041 READ bank3 at cycle 20, reset at cycle 25 -> no rd_data_valid at cycle 34 and all outputs 0 at cycle 26.
REQ-042 With MC_TIMING_TRAS_CHECK_EN defined, ACT at 0 and PRE held from 14 -> PRE accepted at cycle 32; with the macro undefined -> PRE accepted at cycle 14.
